tlp_mwr_gen: RTL
================

Name: tlp_mwr_gen

Overview:
Stage directly downstream of dummy_axi4_if_decoding in the TLP generator path. Consumes each decoded write request (DW address, beat count) and its 256-bit data beats. Emits a PCIe 3DW Memory Write TLP stream: one header beat followed by the payload beats. Assigns a rolling 8-bit tag to each TLP and flags request/data length mismatches.

Parameters:
- ADDR_WIDTH, 32, request address width; only 32-bit (3DW header) is supported.
- DATA_WIDTH, 256, data and TLP beat width in bits; must be a multiple of 32.
- CHUNK_MAX_BEATS, 4, maximum beats per request; CHUNK_MAX_BEATS*DATA_WIDTH/32 must be ≤ 1023.
- REQ_ID, 16'h0100, requester ID placed in header DW1.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- req_valid  in  1  decoded request valid
- req_ready  out  1  request accepted
- req_addr  in  ADDR_WIDTH  byte address; bits [1:0] ignored
- req_len  in  $clog2(CHUNK_MAX_BEATS+1)  beats in chunk, 1..CHUNK_MAX_BEATS
- dat_valid  in  1  payload beat valid
- dat_ready  out  1  payload beat accepted
- dat_data  in  DATA_WIDTH  payload beat
- dat_last  in  1  last beat of chunk, per the decoder
- tlp_valid  out  1  TLP beat valid
- tlp_ready  in  1  downstream accepts beat
- tlp_data  out  DATA_WIDTH  TLP beat
- tlp_sop  out  1  header beat
- tlp_eop  out  1  final payload beat
- err_len  out  1  sticky: req_len was 0 or greater than CHUNK_MAX_BEATS
- err_last  out  1  sticky: dat_last disagreed with the beat counter
- tag_o  out  8  tag of the current or most recent TLP

Behaviour:
- Reset (synchronous, rst=1 at a clk edge):
  - State goes to IDLE; tag, beat_cnt, err_len and err_last clear to 0.
  - All outputs are 0 during and after reset.
  - Reset mid-TLP abandons the TLP. No eop is emitted.
- Handshake rule: a transfer occurs when valid && ready at a clk edge. tlp_valid, once high, holds with stable data until tlp_ready.
- IDLE:
  - req_ready=1; dat_ready=0; tlp_valid=0.
  - On req accept, latch addr[31:2] and len, then go to HDR.
  - If len==0 or len>CHUNK_MAX_BEATS: set err_len, stay in IDLE, emit no TLP, tag unchanged.
- HDR:
  - req_ready=0; dat_ready=0; tlp_valid=1; tlp_sop=1; tlp_eop=0.
  - tlp_data[31:0] = {3'b010, 5'b00000, 1'b0, 3'b000, 4'b0000, 1'b0, 1'b0, 2'b00, 2'b00, LEN10}.
    - LEN10 = len*DATA_WIDTH/32, truncated to 10 bits.
    - Defaults: 1 beat = 8 DW; 4 beats = 32 DW.
  - tlp_data[63:32] = {REQ_ID, tag, 4'hF, 4'hF}.
  - tlp_data[95:64] = {addr[31:2], 2'b00}.
  - All remaining bits of tlp_data are 0.
  - On tlp_ready: clear beat_cnt, go to DATA.
- DATA (combinational pass-through, zero added latency):
  - tlp_valid=dat_valid; dat_ready=tlp_ready; tlp_data=dat_data; tlp_sop=0.
  - tlp_eop = (beat_cnt==len-1) && dat_valid.
  - On each transfer, beat_cnt increments.
  - If dat_last != (beat_cnt==len-1) on a transferred beat, set err_last. The beat still passes through. TLP framing follows the counter, never dat_last.
  - On the eop transfer: tag increments (8-bit, 8'hFF wraps to 8'h00), go to IDLE.
- Back-to-back requests:
  - A new request is accepted in the cycle after the eop transfer.
  - Minimum gap: 1 idle cycle between TLPs, giving len+2 cycles per request at full throughput.
- tag_o reflects the tag register directly.
- err_len and err_last clear only on reset.

Decomposition:
- Shared package tlp_pkg holds:
  - constants FMT_3DW_DATA=3'b010, TYPE_MEM=5'b00000, BE_ALL=4'hF;
  - a typedef for the packed 3DW header struct (dw0, dw1, dw2);
  - a function mwr_hdr(addr, len_dw, req_id, tag) that builds the header.
- No sub-module: the FSM and beat counter form a single module.

Test Plan:
1. req addr=32'h1000_0040, len=1, one beat 256'hA5.., dat_last=1, tlp_ready=1 → header beat with DW0=32'h4000_0008, DW1=32'h0100_00FF, DW2=32'h1000_0040, sop=1; next beat = data with eop=1; tag_o becomes 1.
2. len=4, four beats with dat_last on the 4th; tlp_ready toggles 1/0 every cycle → DW0 length = 10'd32; beats are delivered in order with no duplication while stalled; eop only on the 4th beat; err_last=0.
3. len=2 but dat_last asserted on the 1st beat → err_last=1; TLP still carries 2 payload beats with eop on the 2nd.
4. req_len=0, then req_len=5 → err_len=1; no tlp_valid; tag stays 0; the next valid request is accepted normally.
5. 257 consecutive len=1 requests → tags run 0..255 then wrap to 0; 1 idle cycle between TLPs.
6. rst=1 asserted while in DATA after 2 of 4 beats → outputs 0 on the next cycle; state is IDLE, tag 0, errors cleared; a fresh request then produces a correct header.

Source files
------------

// File: rtl/tlp_pkg.sv
// rtl/tlp_pkg.sv - shared TLP constants, 3DW header layout and header builder
package tlp_pkg;

  localparam logic [2:0] FMT_3DW_DATA = 3'b010;
  localparam logic [4:0] TYPE_MEM     = 5'b00000;
  localparam logic [3:0] BE_ALL       = 4'hF;

  // First member lands in the most significant bits, so dw0 sits at [31:0].
  typedef struct packed {
    logic [31:0] dw2;
    logic [31:0] dw1;
    logic [31:0] dw0;
  } mwr_hdr_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_HDR,
    ST_DATA
  } state_t;

  function automatic mwr_hdr_t mwr_hdr(
    input logic [29:0] addr_dw,
    input logic [9:0]  len_dw,
    input logic [15:0] req_id,
    input logic [7:0]  tag
  );
    mwr_hdr_t h;
    h.dw0 = {FMT_3DW_DATA, TYPE_MEM, 1'b0, 3'b000, 4'b0000, 1'b0, 1'b0, 2'b00, 2'b00, len_dw};
    h.dw1 = {req_id, tag, BE_ALL, BE_ALL};
    h.dw2 = {addr_dw, 2'b00};
    return h;
  endfunction

endpackage

// File: rtl/tlp_mwr_gen_if.sv
// rtl/tlp_mwr_gen_if.sv - request, payload and TLP stream channels of the MWr generator
interface tlp_mwr_gen_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 256,
  parameter int LEN_WIDTH  = 3
);
  logic                  req_valid;
  logic                  req_ready;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic [LEN_WIDTH-1:0]  req_len;

  logic                  dat_valid;
  logic                  dat_ready;
  logic [DATA_WIDTH-1:0] dat_data;
  logic                  dat_last;

  logic                  tlp_valid;
  logic                  tlp_ready;
  logic [DATA_WIDTH-1:0] tlp_data;
  logic                  tlp_sop;
  logic                  tlp_eop;

  modport master (
    output req_valid, req_addr, req_len, dat_valid, dat_data, dat_last, tlp_ready,
    input  req_ready, dat_ready, tlp_valid, tlp_data, tlp_sop, tlp_eop
  );

  modport slave (
    input  req_valid, req_addr, req_len, dat_valid, dat_data, dat_last, tlp_ready,
    output req_ready, dat_ready, tlp_valid, tlp_data, tlp_sop, tlp_eop
  );
endinterface

// File: rtl/tlp_mwr_gen.sv
// rtl/tlp_mwr_gen.sv - turns decoded write requests plus payload beats into 3DW MWr TLPs
module tlp_mwr_gen
  import tlp_pkg::*;
#(
  parameter int          ADDR_WIDTH      = 32,
  parameter int          DATA_WIDTH      = 256,
  parameter int          CHUNK_MAX_BEATS = 4,
  parameter logic [15:0] REQ_ID          = 16'h0100
) (
  input  logic        clk,
  input  logic        rst,
  tlp_mwr_gen_if.slave bus,
  output logic        err_len,
  output logic        err_last,
  output logic [7:0]  tag_o
);

  localparam int LEN_W       = $clog2(CHUNK_MAX_BEATS + 1);
  localparam int DW_PER_BEAT = DATA_WIDTH / 32;

  state_t                  state, state_n;
  logic [ADDR_WIDTH-3:0]   addr_q;
  logic [LEN_W-1:0]        len_q;
  logic [LEN_W-1:0]        beat_cnt;
  logic [7:0]              tag;
  logic                    err_len_q;
  logic                    err_last_q;

  logic                    len_ok;
  logic                    last_beat;
  logic                    dat_xfer;
  logic [9:0]              len_dw;
  mwr_hdr_t                hdr;

  logic                    req_ready;
  logic                    dat_ready;
  logic                    tlp_valid;
  logic                    tlp_sop;
  logic                    tlp_eop;
  logic [DATA_WIDTH-1:0]   tlp_data;

  assign len_ok    = (bus.req_len != '0) && (bus.req_len <= LEN_W'(CHUNK_MAX_BEATS));
  assign last_beat = (beat_cnt == len_q - LEN_W'(1));
  assign len_dw    = 10'(int'(len_q) * DW_PER_BEAT);
  assign hdr       = mwr_hdr(addr_q, len_dw, REQ_ID, tag);
  assign dat_xfer  = (state == ST_DATA) && bus.dat_valid && bus.tlp_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      addr_q     <= '0;
      len_q      <= '0;
      beat_cnt   <= '0;
      tag        <= '0;
      err_len_q  <= 1'b0;
      err_last_q <= 1'b0;
    end else begin
      state <= state_n;
      if (state == ST_IDLE && bus.req_valid) begin
        if (len_ok) begin
          addr_q <= bus.req_addr[ADDR_WIDTH-1:2];
          len_q  <= bus.req_len;
        end else begin
          err_len_q <= 1'b1;
        end
      end
      if (state == ST_HDR && bus.tlp_ready) begin
        beat_cnt <= '0;
      end
      // Framing follows the counter; a disagreeing dat_last is only reported.
      if (dat_xfer) begin
        beat_cnt <= beat_cnt + LEN_W'(1);
        if (bus.dat_last != last_beat) begin
          err_last_q <= 1'b1;
        end
        if (last_beat) begin
          tag <= tag + 8'd1;
        end
      end
    end
  end

  always_comb begin
    state_n   = state;
    req_ready = 1'b0;
    dat_ready = 1'b0;
    tlp_valid = 1'b0;
    tlp_sop   = 1'b0;
    tlp_eop   = 1'b0;
    tlp_data  = '0;
    case (state)
      ST_IDLE: begin
        req_ready = 1'b1;
        if (bus.req_valid && len_ok) begin
          state_n = ST_HDR;
        end
      end
      ST_HDR: begin
        tlp_valid     = 1'b1;
        tlp_sop       = 1'b1;
        tlp_data[95:0] = hdr;
        if (bus.tlp_ready) begin
          state_n = ST_DATA;
        end
      end
      ST_DATA: begin
        tlp_valid = bus.dat_valid;
        dat_ready = bus.tlp_ready;
        tlp_data  = bus.dat_data;
        tlp_eop   = last_beat && bus.dat_valid;
        if (dat_xfer && last_beat) begin
          state_n = ST_IDLE;
        end
      end
      default: state_n = ST_IDLE;
    endcase
    // Outputs are quiet for the whole reset cycle, not just after the edge.
    if (rst) begin
      req_ready = 1'b0;
      dat_ready = 1'b0;
      tlp_valid = 1'b0;
      tlp_sop   = 1'b0;
      tlp_eop   = 1'b0;
      tlp_data  = '0;
    end
  end

  assign bus.req_ready = req_ready;
  assign bus.dat_ready = dat_ready;
  assign bus.tlp_valid = tlp_valid;
  assign bus.tlp_sop   = tlp_sop;
  assign bus.tlp_eop   = tlp_eop;
  assign bus.tlp_data  = tlp_data;

  assign err_len  = err_len_q & ~rst;
  assign err_last = err_last_q & ~rst;
  assign tag_o    = rst ? 8'd0 : tag;

endmodule
